frame_monitor: RTL and testbench

- Streaming sink directly downstream of frame_generator's egress port; consumes 16-bit AXI-stream frames.
- Parses the header (destination MAC, source MAC, payload length, type) and accumulates a 32-bit payload checksum.
- Checks payload length against tlast and counts good and bad frames.
- Exposes results via an 8-bit Avalon-MM slave with the same bus shape as the generator, so software can compare them against the generator's checksum registers.

---
 rtl/frame_pkg.sv | 30 +++
 rtl/frame_checksum.sv | 32 +++
 rtl/frame_monitor.sv | 243 ++++++++++++++++++++++++
 tb/tb_frame_monitor.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame generator/monitor pair.
// Header geometry, register map and parser state encoding.
package frame_pkg;

    localparam int HDR_BEATS = 8;
    localparam int HDR_BYTES = 2 * HDR_BEATS;

    localparam logic [7:0] REG_CTRL     = 8'd0;
    localparam logic [7:0] REG_DST0     = 8'd1;
    localparam logic [7:0] REG_SRC0     = 8'd7;
    localparam logic [7:0] REG_LEN_MSB  = 8'd13;
    localparam logic [7:0] REG_TYPE_MSB = 8'd15;
    localparam logic [7:0] REG_SUM0     = 8'd17;
    localparam logic [7:0] REG_FCNT_LSB = 8'd21;
    localparam logic [7:0] REG_FCNT_MSB = 8'd22;
    localparam logic [7:0] REG_ECNT     = 8'd23;
    localparam logic [7:0] REG_STATUS   = 8'd24;

    localparam int OFS_LEN_MSB = 12;
    localparam int OFS_LEN_LSB = 13;
    localparam int OFS_TYPE_MSB = 14;
    localparam int OFS_TYPE_LSB = 15;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/frame_checksum.sv
// Running 32-bit sum of 16-bit payload words.
// mask_lo zeroes the padding byte of an odd-length frame.
module frame_checksum
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] word,
    input  logic        mask_lo,
    output logic [31:0] sum,
    output logic [31:0] sum_next
);

    logic [15:0] word_m;

    assign word_m   = mask_lo ? {word[15:8], 8'h00} : word;
    assign sum_next = sum + {16'h0000, word_m};

    // Accumulate one word per accepted payload beat
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= 32'h0;
        end else if (clear) begin
            sum <= 32'h0;
        end else if (enable) begin
            sum <= sum_next;
        end
    end

endmodule

// File: rtl/frame_monitor.sv
// Stream sink that parses frames, checks length and sums payload.
// Results and counters are visible over a small 8-bit register bus.
module frame_monitor
    import frame_pkg::*;
#(
    parameter int MAX_LEN = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [7:0]  readdata,
    input  logic [15:0] ingress_port_tdata,
    input  logic        ingress_port_tlast,
    output logic        ingress_port_tready,
    input  logic        ingress_port_tvalid
);

    localparam logic [15:0] MAX_W    = MAX_LEN[15:0];
    localparam logic [2:0]  HDR_LAST = 3'(HDR_BEATS - 1);

    fsm_state_t  state_q, state_d;
    logic        enable_q;
    logic        accept, wr_ctrl, clr_counts;
    logic [2:0]  hdr_cnt_q;
    logic [15:0] pay_cnt_q;
    logic [7:0]  hdr_q    [HDR_BYTES];
    logic [7:0]  hdr_view [HDR_BYTES];
    logic [7:0]  res_q    [HDR_BYTES];
    logic [31:0] res_sum_q;
    logic [15:0] fcnt_q;
    logic [7:0]  ecnt_q;
    logic        len_err_q;
    logic [15:0] len_w;
    logic [16:0] len_p1;
    logic [15:0] pay_beats;
    logic        last_hdr, last_pay, too_long;
    logic        good, bad, sum_clr, sum_en, mask_lo;
    logic [31:0] sum, sum_next;
    logic        busy;
    logic [3:0]  res_idx;
    logic [1:0]  sum_idx;
    logic [7:0]  rd_mux;
    logic        unused_bits;

    assign ingress_port_tready = enable_q;
    assign accept     = ingress_port_tvalid && enable_q;
    assign wr_ctrl    = chipselect && write && (address == REG_CTRL);
    assign clr_counts = wr_ctrl && writedata[1];

    assign len_w     = {hdr_q[OFS_LEN_MSB], hdr_q[OFS_LEN_LSB]};
    assign len_p1    = {1'b0, len_w} + 17'd1;
    assign pay_beats = len_p1[16:1];
    assign last_hdr  = (hdr_cnt_q == HDR_LAST);
    assign last_pay  = (pay_cnt_q == 16'd1);
    assign too_long  = (len_w > MAX_W);
    assign busy      = (state_q != HEADER) || (hdr_cnt_q != 3'd0);
    assign res_idx   = address[3:0] - 4'd1;
    assign sum_idx   = address[1:0] - 2'd1;

    assign unused_bits = ^{writedata[7:2], len_p1[0]};

    frame_checksum u_checksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (sum_clr),
        .enable   (sum_en),
        .word     (ingress_port_tdata),
        .mask_lo  (mask_lo),
        .sum      (sum),
        .sum_next (sum_next)
    );

    // Parser next state and per-beat frame verdicts
    always_comb begin
        state_d = state_q;
        good    = 1'b0;
        bad     = 1'b0;
        sum_clr = 1'b0;
        sum_en  = 1'b0;
        mask_lo = 1'b0;
        if (accept) begin
            unique case (state_q)
                HEADER: begin
                    if (last_hdr) begin
                        sum_clr = 1'b1;
                        if (too_long || len_w == 16'd0) begin
                            good    = ingress_port_tlast && !too_long;
                            bad     = ingress_port_tlast && too_long;
                            state_d = ingress_port_tlast ? HEADER : DRAIN;
                        end else if (ingress_port_tlast) begin
                            bad = 1'b1;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else if (ingress_port_tlast) begin
                        bad = 1'b1;
                    end
                end
                PAYLOAD: begin
                    sum_en  = 1'b1;
                    mask_lo = last_pay && len_w[0];
                    if (ingress_port_tlast) begin
                        good    = last_pay;
                        bad     = !last_pay;
                        state_d = HEADER;
                    end else if (last_pay) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (ingress_port_tlast) begin
                        bad     = 1'b1;
                        state_d = HEADER;
                    end
                end
                default: state_d = HEADER;
            endcase
        end
    end

    // Parser state and beat counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HEADER;
            hdr_cnt_q <= 3'd0;
            pay_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (accept && state_q == HEADER) begin
                if (ingress_port_tlast || last_hdr) begin
                    hdr_cnt_q <= 3'd0;
                end else begin
                    hdr_cnt_q <= hdr_cnt_q + 3'd1;
                end
                if (last_hdr) begin
                    pay_cnt_q <= pay_beats;
                end
            end else if (accept && state_q == PAYLOAD) begin
                pay_cnt_q <= pay_cnt_q - 16'd1;
            end
        end
    end

    // Shadow copy of the header bytes of the frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                hdr_q[i] <= 8'h00;
            end
        end else if (accept && state_q == HEADER) begin
            hdr_q[{hdr_cnt_q, 1'b0}] <= ingress_port_tdata[15:8];
            hdr_q[{hdr_cnt_q, 1'b1}] <= ingress_port_tdata[7:0];
        end
    end

    // Header as it stands on the completing beat (type may be on the wire)
    always_comb begin
        for (int i = 0; i < HDR_BYTES; i++) begin
            hdr_view[i] = hdr_q[i];
        end
        if (state_q == HEADER) begin
            hdr_view[OFS_TYPE_MSB] = ingress_port_tdata[15:8];
            hdr_view[OFS_TYPE_LSB] = ingress_port_tdata[7:0];
        end
    end

    // Result registers and frame counters
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                res_q[i] <= 8'h00;
            end
            res_sum_q <= 32'h0;
            fcnt_q    <= 16'h0;
            ecnt_q    <= 8'h00;
            len_err_q <= 1'b0;
        end else begin
            if (good) begin
                for (int i = 0; i < HDR_BYTES; i++) begin
                    res_q[i] <= hdr_view[i];
                end
                res_sum_q <= (state_q == PAYLOAD) ? sum_next : 32'h0;
                len_err_q <= 1'b0;
            end else if (bad) begin
                len_err_q <= 1'b1;
            end
            if (clr_counts) begin
                fcnt_q <= 16'h0;
                ecnt_q <= 8'h00;
            end else begin
                if (good) begin
                    fcnt_q <= fcnt_q + 16'h1;
                end
                if (bad && ecnt_q != 8'hff) begin
                    ecnt_q <= ecnt_q + 8'h01;
                end
            end
        end
    end

    // Control register
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= 1'b0;
        end else if (wr_ctrl) begin
            enable_q <= writedata[0];
        end
    end

    // Read-side address decode
    always_comb begin
        rd_mux = 8'h00;
        if (address == REG_CTRL) begin
            rd_mux = {7'b0, enable_q};
        end else if (address >= REG_DST0 && address < REG_SUM0) begin
            rd_mux = res_q[res_idx];
        end else if (address >= REG_SUM0 && address < REG_FCNT_LSB) begin
            rd_mux = res_sum_q[{sum_idx, 3'b000} +: 8];
        end else if (address == REG_FCNT_LSB) begin
            rd_mux = fcnt_q[7:0];
        end else if (address == REG_FCNT_MSB) begin
            rd_mux = fcnt_q[15:8];
        end else if (address == REG_ECNT) begin
            rd_mux = ecnt_q;
        end else if (address == REG_STATUS) begin
            rd_mux = {6'b0, len_err_q, busy};
        end
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 8'h00;
        end else if (chipselect && read) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_frame_monitor.sv
// Randomised and directed checks of frame_monitor against a
// frame-level reference model.
module tb_frame_monitor;

    localparam int MAX_LEN = 1500;

    logic        clk;
    logic        reset;
    logic [7:0]  writedata;
    logic        write;
    logic        chipselect;
    logic [7:0]  address;
    logic        read;
    logic [7:0]  readdata;
    logic [15:0] tdata;
    logic        tlast;
    logic        tready;
    logic        tvalid;

    frame_monitor #(.MAX_LEN(MAX_LEN)) dut (
        .clk                 (clk),
        .reset               (reset),
        .writedata           (writedata),
        .write               (write),
        .chipselect          (chipselect),
        .address             (address),
        .read                (read),
        .readdata            (readdata),
        .ingress_port_tdata  (tdata),
        .ingress_port_tlast  (tlast),
        .ingress_port_tready (tready),
        .ingress_port_tvalid (tvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_res [16];
    logic [31:0] exp_sum;
    int          exp_fc;
    int          exp_ec;
    logic        exp_lerr;
    logic [7:0]  hb [16];
    logic [15:0] fq [$];
    logic [7:0]  rd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic send_beat(input logic [15:0] d, input bit last,
                             input bit gaps);
        int w;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        tvalid = 1'b1; tdata = d; tlast = last;
        w = 0;
        while (!tready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!tready) begin
            check("tready_timeout", 32'(tready), 32'd1);
            tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_part(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            send_beat(fq[i], i == fq.size() - 1, gaps);
        end
    endtask

    task automatic rand_hdr(input logic [15:0] len);
        for (int i = 0; i < 16; i++) hb[i] = 8'($urandom);
        hb[12] = len[15:8];
        hb[13] = len[7:0];
    endtask

    task automatic build(input int n_total);
        fq.delete();
        for (int b = 0; b < n_total; b++) begin
            if (b < 8) fq.push_back({hb[2*b], hb[2*b+1]});
            else       fq.push_back(16'($urandom));
        end
    endtask

    // Frame-level verdict from the beat list: header is 8 beats,
    // payload must be exactly ceil(len/2) beats ending on tlast.
    task automatic model_frame();
        int          n;
        int          p;
        bit          ok;
        logic [15:0] len;
        logic [15:0] w;
        logic [31:0] s;
        n = fq.size(); p = 0; ok = 0; s = 0; len = 0;
        if (n >= 8) begin
            len = fq[6];
            if (len == 0) ok = (n == 8);
            else if (len <= MAX_LEN) begin
                p  = (int'(len) + 1) / 2;
                ok = (n == 8 + p);
            end
        end
        if (ok) begin
            for (int i = 0; i < p; i++) begin
                w = fq[8+i];
                if (i == p - 1 && len[0]) w = w & 16'hff00;
                s = s + 32'(w);
            end
            for (int i = 0; i < 8; i++) begin
                exp_res[2*i]   = fq[i][15:8];
                exp_res[2*i+1] = fq[i][7:0];
            end
            exp_sum  = s;
            exp_fc   = (exp_fc + 1) % 65536;
            exp_lerr = 1'b0;
        end else begin
            exp_ec   = (exp_ec < 255) ? exp_ec + 1 : 255;
            exp_lerr = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_res[i] = 8'h00;
        exp_sum = 0; exp_fc = 0; exp_ec = 0; exp_lerr = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        send_part(0, fq.size(), gaps);
        model_frame();
    endtask

    task automatic check_regs(input bit en);
        logic [7:0] d;
        bus_read(8'd0, d);
        check("ctrl", 32'(d), 32'(en));
        for (int a = 1; a <= 16; a++) begin
            bus_read(8'(a), d);
            check($sformatf("hdr_reg%0d", a), 32'(d), 32'(exp_res[a-1]));
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(8'(17 + a), d);
            check($sformatf("sum_byte%0d", a), 32'(d),
                  32'(exp_sum[8*a +: 8]));
        end
        bus_read(8'd21, d);
        check("fcnt_lsb", 32'(d), 32'(exp_fc % 256));
        bus_read(8'd22, d);
        check("fcnt_msb", 32'(d), 32'(exp_fc / 256));
        bus_read(8'd23, d);
        check("ecnt", 32'(d), 32'(exp_ec));
        bus_read(8'd24, d);
        check("status", 32'(d), {30'd0, exp_lerr, 1'b0});
        bus_read(8'd99, d);
        check("unmapped", 32'(d), 32'd0);
    endtask

    initial begin
        int          r;
        int          n;
        int          corr;
        logic [15:0] len;

        reset = 1'b1; writedata = 0; write = 0; chipselect = 0;
        address = 0; read = 0; tdata = 0; tlast = 0; tvalid = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_readdata", 32'(readdata), 32'd0);
        reset = 1'b0;
        check_regs(1'b0);
        bus_write(8'd0, 8'd1);

        // Known frame: len 4, payload 0x0102 + 0x0304
        for (int i = 0; i < 6; i++) hb[i] = 8'(i + 1);
        for (int i = 0; i < 6; i++) hb[6+i] = 8'(10 + i);
        hb[12] = 8'h00; hb[13] = 8'h04; hb[14] = 8'h08; hb[15] = 8'h00;
        build(10);
        fq[8] = 16'h0102; fq[9] = 16'h0304;
        send_frame(1'b0);
        bus_read(8'd17, rd); check("t1_sum0", 32'(rd), 32'h06);
        bus_read(8'd18, rd); check("t1_sum1", 32'(rd), 32'h04);
        bus_read(8'd21, rd); check("t1_fcnt", 32'(rd), 32'h01);
        bus_read(8'd14, rd); check("t1_len_lsb", 32'(rd), 32'h04);
        bus_read(8'd1, rd);  check("t1_dst0", 32'(rd), 32'h01);
        check_regs(1'b1);

        // Odd length with padding byte, read racing the update
        rand_hdr(16'd3);
        build(10);
        fq[8] = 16'h0a0b; fq[9] = 16'h0cff;
        send_part(0, 9, 1'b0);
        @(negedge clk);
        tvalid = 1'b1; tdata = fq[9]; tlast = 1'b1;
        chipselect = 1'b1; read = 1'b1; address = 8'd17;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; chipselect = 1'b0; read = 1'b0;
        check("read_old_value", 32'(readdata), 32'h06);
        model_frame();
        bus_read(8'd17, rd); check("t2_sum0", 32'(rd), 32'h0b);
        bus_read(8'd18, rd); check("t2_sum1", 32'(rd), 32'h16);
        bus_read(8'd23, rd); check("t2_ecnt", 32'(rd), 32'h00);
        check_regs(1'b1);

        // Runt payload keeps the previous results
        rand_hdr(16'd6);
        build(10);
        send_frame(1'b0);
        bus_read(8'd23, rd); check("t3_ecnt", 32'(rd), 32'h01);
        bus_read(8'd24, rd); check("t3_status", 32'(rd), 32'h02);
        bus_read(8'd18, rd); check("t3_sum_kept", 32'(rd), 32'h16);
        rand_hdr(16'd8);
        build(12);
        send_frame(1'b1);
        check_regs(1'b1);

        // Overrun into drain
        rand_hdr(16'd2);
        build(11);
        send_part(0, 10, 1'b0);
        bus_read(8'd24, rd); check("t4_busy_drain", 32'(rd), 32'h01);
        send_part(10, 11, 1'b0);
        model_frame();
        check_regs(1'b1);

        // Disable mid-header, hold valid, then resume
        rand_hdr(16'd5);
        build(11);
        send_part(0, 5, 1'b0);
        bus_write(8'd0, 8'd0);
        @(negedge clk);
        tvalid = 1'b1; tdata = fq[5]; tlast = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("dis_tready", 32'(tready), 32'd0);
        end
        bus_read(8'd24, rd);
        check("dis_busy", 32'(rd), {30'd0, exp_lerr, 1'b1});
        tvalid = 1'b0;
        bus_write(8'd0, 8'd1);
        send_part(5, 11, 1'b0);
        model_frame();
        check_regs(1'b1);

        // clear_counts coincident with a good frame's tlast
        rand_hdr(16'd4);
        build(10);
        send_part(0, 9, 1'b0);
        @(negedge clk);
        tvalid = 1'b1; tdata = fq[9]; tlast = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 8'd0; writedata = 8'd3;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; chipselect = 1'b0; write = 1'b0;
        model_frame();
        exp_fc = 0; exp_ec = 0;
        check_regs(1'b1);

        // Length boundaries
        rand_hdr(16'(MAX_LEN));
        build(8 + MAX_LEN / 2);
        send_frame(1'b0);
        check_regs(1'b1);
        rand_hdr(16'(MAX_LEN + 1));
        build(8);
        send_frame(1'b0);
        rand_hdr(16'(MAX_LEN + 1));
        build(10);
        send_frame(1'b0);
        check_regs(1'b1);
        rand_hdr(16'd0);
        build(8);
        send_frame(1'b0);
        check_regs(1'b1);
        rand_hdr(16'd0);
        build(9);
        send_frame(1'b0);
        rand_hdr(16'd1);
        build(9);
        send_frame(1'b0);
        check_regs(1'b1);

        // Error counter saturation
        for (int k = 0; k < 256; k++) begin
            rand_hdr(16'd10);
            build($urandom_range(1, 7));
            send_frame(1'b0);
        end
        bus_read(8'd23, rd); check("ecnt_sat", 32'(rd), 32'd255);
        check_regs(1'b1);

        // Reset in the middle of a frame
        rand_hdr(16'd6);
        build(11);
        send_part(0, 3, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        check("mid_rst_tready", 32'(tready), 32'd0);
        check_regs(1'b0);
        bus_write(8'd0, 8'd1);

        // Randomised frames with idle gaps
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      len = 16'($urandom_range(0, 24));
            else if (r < 8) len = 16'($urandom_range(MAX_LEN + 1, 4000));
            else            len = 16'($urandom_range(1, 40));
            corr = (len == 0 || len > MAX_LEN) ? 8 : 8 + (int'(len) + 1) / 2;
            r = $urandom_range(0, 5);
            if (r == 0)      n = $urandom_range(1, 7);
            else if (r == 1) n = corr + $urandom_range(1, 3);
            else if (r == 2) n = (corr > 9) ? corr - 1 : corr;
            else             n = corr;
            rand_hdr(len);
            build(n);
            send_frame(1'b1);
            check_regs(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
